// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register, honouring stall, redirect and a halt address.
module fetch_stage #(
    parameter logic [31:0] pc_init   = 32'h8002_0000,
    parameter logic [31:0] halt_addr = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_in,
    output logic        im_enable,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
    logic        halted_reg, halted_next;
    logic        misaligned_reg, misaligned_next;
    logic [31:0] fetch_count_reg, fetch_count_next;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= RUN;
            pc_reg            <= pc_init;
            ifid_valid_reg    <= 1'b0;
            ifid_instr_reg    <= '0;
            ifid_pc_reg       <= '0;
            ifid_pc_plus4_reg <= '0;
            halted_reg        <= 1'b0;
            misaligned_reg    <= 1'b0;
            fetch_count_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            ifid_valid_reg    <= ifid_valid_next;
            ifid_instr_reg    <= ifid_instr_next;
            ifid_pc_reg       <= ifid_pc_next;
            ifid_pc_plus4_reg <= ifid_pc_plus4_next;
            halted_reg        <= halted_next;
            misaligned_reg    <= misaligned_next;
            fetch_count_reg   <= fetch_count_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        ifid_valid_next    = ifid_valid_reg;
        ifid_instr_next    = ifid_instr_reg;
        ifid_pc_next       = ifid_pc_reg;
        ifid_pc_plus4_next = ifid_pc_plus4_reg;
        halted_next        = halted_reg;
        misaligned_next    = misaligned_reg;
        fetch_count_next   = fetch_count_reg;
        unique case (state_reg)
            RUN: begin
                // Redirect wins over stall: a flush must never be lost to a hold.
                if (redirect_valid) begin
                    pc_next         = {redirect_pc[31:2], 2'b00};
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = '0;
                    if (redirect_pc[1:0] != 2'b00)
                        misaligned_next = 1'b1;
                end else if (stall) begin
                    // everything holds
                end else if (pc_reg == halt_addr) begin
                    state_next      = HALT;
                    halted_next     = 1'b1;
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = '0;
                end else begin
                    ifid_instr_next    = instr_in;
                    ifid_pc_next       = pc_reg;
                    ifid_pc_plus4_next = pc_plus4;
                    ifid_valid_next    = 1'b1;
                    pc_next            = pc_plus4;
                    fetch_count_next   = fetch_count_reg + 32'd1;
                end
            end
            HALT: begin
                // only reset leaves HALT
            end
            default: state_next = RUN;
        endcase
    end

    assign instr_addr    = pc_reg;
    assign im_enable     = (state_reg == RUN) && reset;
    assign ifid_valid    = ifid_valid_reg;
    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc       = ifid_pc_reg;
    assign ifid_pc_plus4 = ifid_pc_plus4_reg;
    assign halted        = halted_reg;
    assign misaligned    = misaligned_reg;
    assign fetch_count   = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the instruction memory returns addr + 0x10000000
// so every expected IF/ID word below is a hand-computed constant.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic        im_enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    int n_compared;
    int n_mismatched;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .instr_addr     (instr_addr),
        .instr_in       (instr_in),
        .im_enable      (im_enable),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .halted         (halted),
        .misaligned     (misaligned),
        .fetch_count    (fetch_count)
    );

    assign instr_in = instr_addr + 32'h1000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
        end else begin
            $display("ok   %s: %08h", tag, observed);
        end
    endtask

    // advance one rising edge and land on the following falling edge
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();

        // reset state
        check_value("rst_addr", instr_addr, 32'h8002_0000);
        check_value("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_value("rst_ifid_pc", ifid_pc, 32'd0);
        check_value("rst_count", fetch_count, 32'd0);
        check_value("rst_im_en", {31'd0, im_enable}, 32'd0);

        // sequential fetch
        reset = 1'b1;
        #1;
        check_value("seq_addr0", instr_addr, 32'h8002_0000);
        check_value("seq_im_en", {31'd0, im_enable}, 32'd1);
        step();
        check_value("seq_addr1", instr_addr, 32'h8002_0004);
        check_value("seq_ifid_pc1", ifid_pc, 32'h8002_0000);
        check_value("seq_instr1", ifid_instr, 32'h9002_0000);
        check_value("seq_valid1", {31'd0, ifid_valid}, 32'd1);
        step();
        check_value("seq_addr2", instr_addr, 32'h8002_0008);
        check_value("seq_ifid_pc2", ifid_pc, 32'h8002_0004);
        check_value("seq_plus4_2", ifid_pc_plus4, 32'h8002_0008);
        check_value("seq_count2", fetch_count, 32'd2);

        // stall two cycles at 80020008
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_value("stall_addr", instr_addr, 32'h8002_0008);
            check_value("stall_ifid_pc", ifid_pc, 32'h8002_0004);
            check_value("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        check_value("resume_addr", instr_addr, 32'h8002_000C);
        check_value("resume_ifid_pc", ifid_pc, 32'h8002_0008);
        check_value("resume_count", fetch_count, 32'd3);
        step();
        check_value("pre_redir_addr", instr_addr, 32'h8002_0010);
        check_value("pre_redir_instr", ifid_instr, 32'h9002_000C);

        // redirect with simultaneous stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0040;
        stall          = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check_value("redir_addr", instr_addr, 32'h8002_0040);
        check_value("redir_valid", {31'd0, ifid_valid}, 32'd0);
        check_value("redir_instr", ifid_instr, 32'd0);
        check_value("redir_count", fetch_count, 32'd4);
        step();
        check_value("post_redir_pc", ifid_pc, 32'h8002_0040);
        check_value("post_redir_valid", {31'd0, ifid_valid}, 32'd1);
        check_value("post_redir_plus4", ifid_pc_plus4, 32'h8002_0044);
        check_value("post_redir_count", fetch_count, 32'd5);
        check_value("aligned_flag", {31'd0, misaligned}, 32'd0);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0046;
        step();
        redirect_valid = 1'b0;
        check_value("mis_addr", instr_addr, 32'h8002_0044);
        check_value("mis_flag", {31'd0, misaligned}, 32'd1);
        step();
        check_value("mis_sticky", {31'd0, misaligned}, 32'd1);
        check_value("mis_next_addr", instr_addr, 32'h8002_0048);
        check_value("mis_count", fetch_count, 32'd6);

        // redirect to halt address
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0000;
        step();
        redirect_valid = 1'b0;
        check_value("hredir_addr", instr_addr, 32'd0);
        check_value("hredir_im_en", {31'd0, im_enable}, 32'd1);
        check_value("hredir_halted", {31'd0, halted}, 32'd0);
        step();
        check_value("halt_flag", {31'd0, halted}, 32'd1);
        check_value("halt_im_en", {31'd0, im_enable}, 32'd0);
        check_value("halt_valid", {31'd0, ifid_valid}, 32'd0);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0100;
        step();
        stall = 1'b0;
        step();
        redirect_valid = 1'b0;
        check_value("halt_hold_addr", instr_addr, 32'd0);
        check_value("halt_hold_count", fetch_count, 32'd6);
        check_value("halt_hold_flag", {31'd0, halted}, 32'd1);
        check_value("halt_mis_sticky", {31'd0, misaligned}, 32'd1);

        // leave HALT through reset, run to 80020020, then reset between edges
        reset = 1'b0;
        #1;
        check_value("exit_halt", {31'd0, halted}, 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_value("run8_addr", instr_addr, 32'h8002_0020);
        check_value("run8_count", fetch_count, 32'd8);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_value("async_addr", instr_addr, 32'h8002_0000);
        check_value("async_valid", {31'd0, ifid_valid}, 32'd0);
        check_value("async_count", fetch_count, 32'd0);
        check_value("async_mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // PC wrap onto halt address; stall at halt address takes priority
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check_value("wrap_addr0", instr_addr, 32'hFFFF_FFFC);
        step();
        check_value("wrap_addr1", instr_addr, 32'd0);
        check_value("wrap_plus4", ifid_pc_plus4, 32'd0);
        check_value("wrap_instr", ifid_instr, 32'h0FFF_FFFC);
        check_value("wrap_count", fetch_count, 32'd1);
        stall = 1'b1;
        step();
        stall = 1'b0;
        check_value("wrap_stall_halted", {31'd0, halted}, 32'd0);
        check_value("wrap_stall_valid", {31'd0, ifid_valid}, 32'd1);
        step();
        check_value("wrap_halted", {31'd0, halted}, 32'd1);
        check_value("wrap_halt_valid", {31'd0, ifid_valid}, 32'd0);
        check_value("wrap_halt_count", fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
